// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the main-memory line arbiter.
package mem_arb_pkg;

  localparam int DEF_LINE_W      = 128;
  localparam int DEF_LINE_ADDR_W = 10;

  typedef logic [DEF_LINE_W-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_line_arbiter.sv
// Serialises I-cache and D-cache line transactions onto the single main-memory port,
// one outstanding access at a time, round-robin on conflict, with an abort watchdog.
module mem_line_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_W      = DEF_LINE_W,
  parameter int LINE_ADDR_W = DEF_LINE_ADDR_W,
  parameter int TIMEOUT     = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   ic_req,
  input  logic [LINE_ADDR_W-1:0] ic_addr,
  output logic                   ic_ready,
  output logic [LINE_W-1:0]      ic_rdata,
  input  logic                   dc_req,
  input  logic                   dc_we,
  input  logic [LINE_ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0]      dc_wdata,
  output logic                   dc_ready,
  output logic [LINE_W-1:0]      dc_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [LINE_ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]      mem_wdata,
  input  logic [LINE_W-1:0]      mem_rdata,
  input  logic                   mem_ready,
  output logic                   busy,
  output logic                   owner,
  output logic                   err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t             r_state;
  owner_t                 r_last_grant;
  owner_t                 r_owner;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_ic_ready;
  logic                   r_dc_ready;
  logic [LINE_W-1:0]      r_ic_rdata;
  logic [LINE_W-1:0]      r_dc_rdata;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [LINE_ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0]      r_mem_wdata;
  logic                   r_busy;
  logic                   r_err;

  logic                   w_any_req;
  logic                   w_grant_dc;

  // On a conflict the requester that did not win last time is served.
  always_comb begin
    w_any_req = ic_req | dc_req;
    if (ic_req && dc_req) begin
      w_grant_dc = (r_last_grant == OWN_IC);
    end else begin
      w_grant_dc = dc_req;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= OWN_IC;
      r_owner      <= OWN_IC;
      r_cnt        <= '0;
      r_ic_ready   <= 1'b0;
      r_dc_ready   <= 1'b0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
          r_err      <= 1'b0;
          r_cnt      <= '0;
          if (w_any_req) begin
            r_state   <= MEM;
            r_busy    <= 1'b1;
            r_mem_req <= 1'b1;
            if (w_grant_dc) begin
              r_mem_addr   <= dc_addr;
              r_mem_we     <= dc_we;
              r_mem_wdata  <= dc_wdata;
              r_owner      <= OWN_DC;
              r_last_grant <= OWN_DC;
            end else begin
              r_mem_addr   <= ic_addr;
              r_mem_we     <= 1'b0;
              r_mem_wdata  <= '0;
              r_owner      <= OWN_IC;
              r_last_grant <= OWN_IC;
            end
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        MEM: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= DONE;
            if (r_owner == OWN_DC) begin
              r_dc_rdata <= mem_rdata;
              r_dc_ready <= 1'b1;
            end else begin
              r_ic_rdata <= mem_rdata;
              r_ic_ready <= 1'b1;
            end
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Watchdog abort: complete the handshake with a zero line and flag it.
            r_mem_req <= 1'b0;
            r_state   <= DONE;
            r_err     <= 1'b1;
            if (r_owner == OWN_DC) begin
              r_dc_rdata <= '0;
              r_dc_ready <= 1'b1;
            end else begin
              r_ic_rdata <= '0;
              r_ic_ready <= 1'b1;
            end
          end else begin
            r_state <= MEM;
          end
        end
        DONE: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_cnt      <= '0;
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
          r_err      <= 1'b0;
        end
        default: begin
          r_state    <= IDLE;
          r_busy     <= 1'b0;
          r_mem_req  <= 1'b0;
          r_cnt      <= '0;
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
          r_err      <= 1'b0;
        end
      endcase
    end
  end

  assign ic_ready  = r_ic_ready;
  assign ic_rdata  = r_ic_rdata;
  assign dc_ready  = r_dc_ready;
  assign dc_rdata  = r_dc_rdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign owner     = r_owner;
  assign err       = r_err;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Self-checking bench for mem_line_arbiter: directed vector table, arbitration and
// reset sequences, then random traffic against a line-level memory reference.
module tb_mem_line_arbiter;
  import mem_arb_pkg::*;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        ic_req    = 1'b0;
  logic [9:0]  ic_addr   = 10'h000;
  logic        ic_ready;
  line_t       ic_rdata;
  logic        dc_req    = 1'b0;
  logic        dc_we     = 1'b0;
  logic [9:0]  dc_addr   = 10'h000;
  line_t       dc_wdata  = 128'h0;
  logic        dc_ready;
  line_t       dc_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  line_t       mem_wdata;
  line_t       mem_rdata = 128'h0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        owner;
  logic        err;

  mem_line_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner), .err(err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  line_t env_mem [1024];
  line_t ref_mem [1024];
  int    wait_cycles = 0;
  int    rsp_cnt     = 0;
  logic  mem_dead    = 1'b0;
  logic  rand_waits  = 1'b0;
  logic  noise       = 1'b0;

  localparam line_t C_DEAD = 128'hCAFEF00D_01234567_89ABCDEF_DEADBEEF;
  localparam line_t C_3FF  = 128'h3FF03FF0_11112222_33334444_55556666;

  // Main-memory model: answers after wait_cycles, reads return the old line, writes store.
  always @(negedge clock) begin
    if (mem_req && !mem_dead) begin
      if (rsp_cnt >= wait_cycles) begin
        mem_ready = 1'b1;
        mem_rdata = env_mem[mem_addr];
        if (mem_we) env_mem[mem_addr] = mem_wdata;
        rsp_cnt = 0;
        if (rand_waits) wait_cycles = $urandom_range(0, 3);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
        rsp_cnt++;
      end
    end else begin
      mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      rsp_cnt   = 0;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        who;
    logic        we;
    logic [9:0]  addr;
    line_t       wdata;
    int          waits;
    logic        dead;
    int          exp_cyc;
    line_t       exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt [6];
  logic got_ord [$];
  logic exp_a [4];
  logic exp_b [3];

  task automatic serve(input int n_ic, input int n_dc);
    int ni;
    int nd;
    ni = n_ic;
    nd = n_dc;
    got_ord.delete();
    ic_addr = 10'h005;
    dc_addr = 10'h3FF;
    dc_we   = 1'b0;
    ic_req  = (ni > 0);
    dc_req  = (nd > 0);
    for (int c = 0; c < 400 && (ni > 0 || nd > 0); c++) begin
      @(negedge clock);
      if (ic_ready) begin
        got_ord.push_back(1'b0);
        chk("rr_ic_owner", 128'(owner), 128'(0));
        ni--;
        if (ni <= 0) ic_req = 1'b0;
      end
      if (dc_ready) begin
        got_ord.push_back(1'b1);
        chk("rr_dc_owner", 128'(owner), 128'(1));
        nd--;
        if (nd <= 0) dc_req = 1'b0;
      end
    end
    ic_req = 1'b0;
    dc_req = 1'b0;
    @(negedge clock);
  endtask

  int   got_cyc;
  int   mreq_cyc;
  vec_t v;
  int   ic_left, dc_left, ic_age, dc_age;
  logic [9:0] ic_a, dc_a;
  logic       dc_w;
  line_t      dc_d;

  initial begin
    for (int i = 0; i < 1024; i++) env_mem[i] = {4{32'hA5A50000 | 32'(i)}};
    env_mem[10'h005] = C_DEAD;
    env_mem[10'h3FF] = C_3FF;

    vt[0] = '{1'b0, 1'b0, 10'h005, 128'h0, 2, 1'b0, 4,  C_DEAD,   1'b0};
    vt[1] = '{1'b1, 1'b1, 10'h000, 128'h5, 0, 1'b0, 2,  128'h0,   1'b0};
    vt[2] = '{1'b1, 1'b0, 10'h000, 128'h0, 1, 1'b0, 3,  128'h5,   1'b0};
    vt[3] = '{1'b0, 1'b0, 10'h3FF, 128'h0, 3, 1'b0, 5,  C_3FF,    1'b0};
    vt[4] = '{1'b1, 1'b0, 10'h005, 128'h0, 0, 1'b0, 2,  C_DEAD,   1'b0};
    vt[5] = '{1'b0, 1'b0, 10'h007, 128'h0, 0, 1'b1, 65, 128'h0,   1'b1};
    exp_a = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_b = '{1'b1, 1'b0, 1'b1};

    repeat (2) @(negedge clock);
    chk("rst_outputs", {ic_ready, dc_ready, mem_req, mem_we, busy, owner, err, 1'b0},
        128'h0);
    chk("rst_ic_rdata", ic_rdata, 128'h0);
    chk("rst_dc_rdata", dc_rdata, 128'h0);
    chk("rst_mem_addr", 128'(mem_addr), 128'h0);
    chk("rst_mem_wdata", mem_wdata, 128'h0);
    reset = 1'b0;
    @(negedge clock);

    // Single-requester vectors: latency, latched request fields, data and watchdog.
    for (int k = 0; k < 6; k++) begin
      v = vt[k];
      mem_dead    = v.dead;
      wait_cycles = v.waits;
      if (v.who) begin
        dc_addr = v.addr; dc_we = v.we; dc_wdata = v.wdata; dc_req = 1'b1;
      end else begin
        ic_addr = v.addr; ic_req = 1'b1;
      end
      got_cyc  = 0;
      mreq_cyc = 0;
      for (int c = 1; c <= 200; c++) begin
        @(negedge clock);
        if (mem_req) begin
          mreq_cyc++;
          chk("tbl_mem_addr", 128'(mem_addr), 128'(v.addr));
          chk("tbl_mem_we", 128'(mem_we), 128'(v.who & v.we));
          if (v.who && v.we) chk("tbl_mem_wdata", mem_wdata, v.wdata);
        end
        if (c == 1) begin
          ic_addr = ~v.addr; dc_addr = ~v.addr; dc_wdata = ~v.wdata;
        end
        if (v.who ? dc_ready : ic_ready) begin
          got_cyc = c;
          break;
        end
      end
      chk("tbl_ready_cycle", 128'(got_cyc), 128'(v.exp_cyc));
      chk("tbl_memreq_cycles", 128'(mreq_cyc), 128'(v.exp_cyc - 1));
      chk("tbl_owner", 128'(owner), 128'(v.who));
      chk("tbl_err", 128'(err), 128'(v.exp_err));
      chk("tbl_other_ready", 128'(v.who ? ic_ready : dc_ready), 128'(0));
      if (!v.we) chk("tbl_rdata", v.who ? dc_rdata : ic_rdata, v.exp_rdata);
      ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
      @(negedge clock);
      chk("tbl_one_cycle_ready", 128'({ic_ready, dc_ready, err}), 128'(0));
      chk("tbl_idle_busy", 128'(busy), 128'(0));
    end
    mem_dead = 1'b0;
    chk("wb_mem0", 128'(env_mem[0][31:0]), 128'(5));

    // Round-robin: conflicts alternate starting with the D-cache, then DC/IC/DC.
    wait_cycles = 1;
    serve(2, 2);
    chk("rr_a_len", 128'(got_ord.size()), 128'(4));
    for (int i = 0; i < 4; i++)
      if (i < got_ord.size()) chk("rr_a_order", 128'(got_ord[i]), 128'(exp_a[i]));
    serve(1, 2);
    chk("rr_b_len", 128'(got_ord.size()), 128'(3));
    for (int i = 0; i < 3; i++)
      if (i < got_ord.size()) chk("rr_b_order", 128'(got_ord[i]), 128'(exp_b[i]));

    // Reset in the middle of a memory access, then the held request is served again.
    mem_dead = 1'b1;
    dc_we = 1'b0; dc_addr = 10'h005; dc_req = 1'b1;
    repeat (6) @(negedge clock);
    chk("rst_mid_memreq_before", 128'(mem_req), 128'(1));
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs", 128'({mem_req, busy, ic_ready, dc_ready, err, owner}), 128'(0));
    @(negedge clock);
    chk("rst_mid_hold", 128'({mem_req, busy, dc_ready}), 128'(0));
    reset = 1'b0; mem_dead = 1'b0; wait_cycles = 0;
    got_cyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (dc_ready) begin got_cyc = c; break; end
    end
    chk("rst_regrant_cycle", 128'(got_cyc), 128'(2));
    chk("rst_regrant_rdata", dc_rdata, C_DEAD);
    dc_req = 1'b0;
    @(negedge clock);

    // Random traffic on a small address window; reference keeps line contents by completion order.
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    rand_waits = 1'b1; noise = 1'b1;
    ic_left = 60; dc_left = 60; ic_age = 0; dc_age = 0;
    for (int c = 0; c < 6000 && (ic_left > 0 || dc_left > 0); c++) begin
      @(negedge clock);
      if (ic_req) ic_age++;
      if (dc_req) dc_age++;
      if (ic_ready) begin
        chk("rnd_ic_active", 128'(ic_req), 128'(1));
        chk("rnd_ic_err", 128'(err), 128'(0));
        chk("rnd_ic_other", 128'(dc_ready), 128'(0));
        chk("rnd_ic_rdata", ic_rdata, ref_mem[ic_a]);
        chk("rnd_ic_wait_ok", 128'(ic_age <= 14), 128'(1));
        ic_req = 1'b0; ic_left--;
      end
      if (dc_ready) begin
        chk("rnd_dc_active", 128'(dc_req), 128'(1));
        chk("rnd_dc_err", 128'(err), 128'(0));
        chk("rnd_dc_wait_ok", 128'(dc_age <= 14), 128'(1));
        if (dc_w) ref_mem[dc_a] = dc_d;
        else chk("rnd_dc_rdata", dc_rdata, ref_mem[dc_a]);
        dc_req = 1'b0; dc_left--;
      end
      if (!ic_req && ic_left > 0 && $urandom_range(0, 2) == 0) begin
        ic_a = 10'($urandom_range(0, 15));
        ic_addr = ic_a; ic_req = 1'b1; ic_age = 0;
      end
      if (!dc_req && dc_left > 0 && $urandom_range(0, 2) == 0) begin
        dc_a = 10'($urandom_range(0, 15));
        dc_w = 1'($urandom_range(0, 1));
        dc_d = {$urandom, $urandom, $urandom, $urandom};
        dc_addr = dc_a; dc_we = dc_w; dc_wdata = dc_d; dc_req = 1'b1; dc_age = 0;
      end
    end
    chk("rnd_all_done", 128'(ic_left + dc_left), 128'(0));
    ic_req = 1'b0; dc_req = 1'b0; noise = 1'b0;
    repeat (8) @(negedge clock);
    for (int i = 0; i < 16; i++) chk("rnd_mem_line", env_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
- Shares the single 128-bit-line main memory port between the instruction-cache refill path and the data-cache refill/writeback path, including the writebacks issued by the cache-drain instruction.
- Sits between the two caches and main_memory in the MEM subsystem.
- Serialises line transactions with a one-outstanding-request FSM and round-robin tie-breaking.
- A watchdog aborts any memory access that never completes.

Parameters:
- LINE_W, 128, memory line width in bits.
- LINE_ADDR_W, 10, line index width (1024 lines).
- TIMEOUT, 64, maximum cycles to wait for mem_ready before aborting.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ic_req  in  1  I-cache line read request; held until ic_ready.
- ic_addr  in  LINE_ADDR_W  I-cache line index.
- ic_ready  out  1  one-cycle completion pulse to the I-cache.
- ic_rdata  out  LINE_W  returned line; valid while ic_ready=1.
- dc_req  in  1  D-cache request; held until dc_ready.
- dc_we  in  1  1 = writeback of dc_wdata, 0 = line read.
- dc_addr  in  LINE_ADDR_W  D-cache line index.
- dc_wdata  in  LINE_W  writeback line.
- dc_ready  out  1  one-cycle completion pulse to the D-cache.
- dc_rdata  out  LINE_W  returned line; valid while dc_ready=1.
- mem_req  out  1  request to main memory.
- mem_we  out  1  write enable to main memory.
- mem_addr  out  LINE_ADDR_W  line index to main memory.
- mem_wdata  out  LINE_W  write data to main memory.
- mem_rdata  in  LINE_W  read data from main memory.
- mem_ready  in  1  memory completion; sampled only while mem_req=1.
- busy  out  1  1 in any state other than IDLE.
- owner  out  1  current grant: 0 = I-cache, 1 = D-cache.
- err  out  1  pulse concurrent with ready when the watchdog aborted the transaction.

Behaviour:
- All outputs are registered.
- Reset values:
  - every output = 0;
  - state = IDLE;
  - last_grant = IC;
  - watchdog counter = 0.
- Asynchronous reset mid-transaction: mem_req drops immediately and the in-flight access is abandoned. No ready pulse is issued after reset.
- FSM states: IDLE, MEM, DONE.
- IDLE:
  - Requests are sampled at the clock edge.
  - Exactly one request: grant it.
  - Both requests: grant the one not equal to last_grant, so the D-cache wins the first conflict after reset.
  - On grant: latch addr, we (forced to 0 for the I-cache) and wdata into mem_* registers; set owner; update last_grant; go to MEM.
- MEM:
  - mem_req=1 and mem_addr/mem_we/mem_wdata stay stable.
  - Requester inputs are ignored in this state.
  - The counter increments each cycle.
  - On an edge with mem_ready=1: capture mem_rdata into the owner's rdata register (writes capture mem_rdata as-is, content don't-care); drop mem_req; go to DONE.
  - If the counter reaches TIMEOUT-1 without mem_ready: rdata = 0, err = 1, drop mem_req, go to DONE.
- DONE:
  - Owner's ready = 1 for exactly one cycle. The other requester's ready stays 0.
  - Next state is always IDLE; the counter clears.
- Requester rule: deassert req on the edge that samples ready=1. Keeping req high in the following cycle starts a new transaction.
- Latency:
  - req sampled at edge 0, mem_req high from cycle 1.
  - Zero-wait memory (mem_ready in cycle 1) gives ready in cycle 2: 3 cycles minimum.
  - Each memory wait cycle adds 1.
- The losing requester keeps its req high and is served next. Worst-case wait is one full transaction plus the IDLE cycle.
- A requester changing addr or wdata while granted has no effect; the latched values are used.
- mem_ready while mem_req=0 is ignored.
- rdata registers hold their value after DONE until overwritten.

Decomposition:
- Package mem_arb_pkg holds:
  - LINE_W and LINE_ADDR_W defaults;
  - typedef line_t (logic [LINE_W-1:0]);
  - enum arb_state_t {IDLE, MEM, DONE};
  - enum owner_t {OWN_IC=0, OWN_DC=1}.
- Single module, no sub-module. The round-robin choice is a two-input expression inside the IDLE logic.

Test Plan:
- I-cache alone: ic_req, addr 0x005; memory returns 0x...DEADBEEF after 2 wait cycles -> ic_ready pulse in cycle 4, ic_rdata = 0x...DEADBEEF, owner = 0, dc_ready stays 0.
- D-cache writeback: dc_we=1, addr 0x000, wdata = {0,0,0,5}; zero-wait memory -> mem_we=1 and mem_wdata held during MEM, dc_ready in cycle 2, memArray[0][31:0] = 5.
- Simultaneous requests right after reset, both held -> D-cache granted first (owner=1), I-cache second; a third conflict grants the D-cache again (alternation).
- Back-to-back D-cache requests with I-cache req held throughout -> order is DC, IC, DC; no requester is starved.
- Memory never asserts mem_ready, TIMEOUT=64 -> mem_req drops after 64 MEM cycles; ready and err pulse together, rdata = 0; FSM returns to IDLE.
- Reset asserted in the middle of MEM -> mem_req, busy and ready are 0 immediately; after release the same request is re-granted from IDLE; no spurious ready.
